// File: rtl/promedio_pkg.sv
// Shared types and sizing helpers for the windowed sample averager.
package promedio_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    // Accumulator width that holds a full window of N-bit samples without wrap.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned log2_win);
        return n + log2_win;
    endfunction

    // Half-LSB of the mean, added before the shift when rounding is enabled.
    function automatic int unsigned round_const(input int unsigned log2_win, input bit round);
        return round ? (32'd1 << (log2_win - 32'd1)) : 32'd0;
    endfunction

endpackage

// File: rtl/promedio_minmax.sv
// Running minimum/maximum registers for one averaging window.
module promedio_minmax #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_i,
    input  logic         upd_i,
    input  logic [N-1:0] sample_i,
    output logic [N-1:0] min_nxt_c,
    output logic [N-1:0] max_nxt_c
);

    logic [N-1:0] min_q, min_d;
    logic [N-1:0] max_q, max_d;

    // Extremes including the current sample, used for both update and final capture.
    assign min_nxt_c = (sample_i < min_q) ? sample_i : min_q;
    assign max_nxt_c = (sample_i > max_q) ? sample_i : max_q;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (seed_i) begin
            min_d = '1;
            max_d = '0;
        end else if (upd_i) begin
            min_d = min_nxt_c;
            max_d = max_nxt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/promedio_window.sv
// Windowed averager: accumulates 2^LOG2_WIN valid samples and reports mean, sum, min and max.
module promedio_window
    import promedio_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned LOG2_WIN = 7,
    parameter bit          ROUND    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  in_valid,
    input  logic [N-1:0]          in,
    output logic [N-1:0]          out,
    output logic [N-1:0]          out_min,
    output logic [N-1:0]          out_max,
    output logic [N+LOG2_WIN-1:0] sum_out,
    output logic                  sum_redy,
    output logic                  busy
);

    localparam int unsigned AW  = acc_width(N, LOG2_WIN);
    localparam int unsigned RW  = AW + 1;
    localparam int unsigned CW  = LOG2_WIN;
    localparam int unsigned RND = round_const(LOG2_WIN, ROUND);

    state_e         state_q, state_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   mean_q, min_q, max_q;
    logic [AW-1:0]  sum_q;
    logic           redy_q, busy_q;

    logic           seed_c, upd_c, load_c, final_c;
    logic [AW-1:0]  acc_sum_c;
    logic [RW-1:0]  rnd_sum_c;
    logic [N-1:0]   mean_c;
    logic [N-1:0]   min_nxt_c, max_nxt_c;

    assign acc_sum_c = acc_q + AW'(in);
    // One extra bit so adding the rounding constant to an all-ones window cannot wrap.
    assign rnd_sum_c = RW'(acc_sum_c) + RW'(RND);
    assign mean_c    = N'(rnd_sum_c >> LOG2_WIN);
    assign final_c   = (state_q == ST_ACC) && in_valid && (cnt_q == '1);

    promedio_minmax #(
        .N (N)
    ) u_minmax (
        .clk       (clk),
        .rst_n     (reset),
        .seed_i    (seed_c),
        .upd_i     (upd_c),
        .sample_i  (in),
        .min_nxt_c (min_nxt_c),
        .max_nxt_c (max_nxt_c)
    );

    // Next-state, accumulator/counter update and result-load strobes.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        seed_c  = 1'b0;
        upd_c   = 1'b0;
        load_c  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start || continuous) begin
                        state_d = ST_ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        seed_c  = 1'b1;
                    end
                end
                ST_ACC: begin
                    if (final_c) begin
                        load_c = 1'b1;
                        acc_d  = '0;
                        cnt_d  = '0;
                        if (continuous) begin
                            seed_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (in_valid) begin
                        acc_d = acc_sum_c;
                        cnt_d = cnt_q + CW'(1);
                        upd_c = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            redy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_ACC);
            redy_q  <= load_c;
        end
    end

    // Result registers change only on the final-sample edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mean_q <= '0;
            min_q  <= '0;
            max_q  <= '0;
            sum_q  <= '0;
        end else if (load_c) begin
            mean_q <= mean_c;
            min_q  <= min_nxt_c;
            max_q  <= max_nxt_c;
            sum_q  <= acc_sum_c;
        end
    end

    assign out      = mean_q;
    assign out_min  = min_q;
    assign out_max  = max_q;
    assign sum_out  = sum_q;
    assign sum_redy = redy_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_promedio_window.sv
// Self-checking bench for promedio_window (N=8, window of 4) against a queue-based reference model.
module tb_promedio_window;

    localparam int unsigned N   = 8;
    localparam int unsigned L   = 2;
    localparam int          WIN = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         start;
    logic         continuous;
    logic         in_valid;
    logic [N-1:0] in_s;

    logic [N-1:0]   r1_out, r1_min, r1_max, r0_out, r0_min, r0_max;
    logic [N+L-1:0] r1_sum, r0_sum;
    logic           r1_redy, r1_busy, r0_redy, r0_busy;

    promedio_window #(.N(N), .LOG2_WIN(L), .ROUND(1'b1)) u_dut_r1 (
        .clk(clk), .reset(reset), .en(en), .start(start), .continuous(continuous),
        .in_valid(in_valid), .in(in_s), .out(r1_out), .out_min(r1_min), .out_max(r1_max),
        .sum_out(r1_sum), .sum_redy(r1_redy), .busy(r1_busy)
    );

    promedio_window #(.N(N), .LOG2_WIN(L), .ROUND(1'b0)) u_dut_r0 (
        .clk(clk), .reset(reset), .en(en), .start(start), .continuous(continuous),
        .in_valid(in_valid), .in(in_s), .out(r0_out), .out_min(r0_min), .out_max(r0_max),
        .sum_out(r0_sum), .sum_redy(r0_redy), .busy(r0_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;
    int pulses[$];

    // Reference model: current window contents and last published results.
    bit m_active;
    int win_q[$];
    int h_sum, h_m1, h_m0, h_min, h_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit exp_redy);
        chk({tag, ".redy"},    32'(r1_redy), 32'(exp_redy));
        chk({tag, ".redy_r0"}, 32'(r0_redy), 32'(exp_redy));
        chk({tag, ".busy"},    32'(r1_busy), 32'(m_active));
        chk({tag, ".sum"},     32'(r1_sum),  32'(h_sum));
        chk({tag, ".mean_r1"}, 32'(r1_out),  32'(h_m1));
        chk({tag, ".mean_r0"}, 32'(r0_out),  32'(h_m0));
        chk({tag, ".min"},     32'(r1_min),  32'(h_min));
        chk({tag, ".max"},     32'(r1_max),  32'(h_max));
    endtask

    // Drive one clock cycle, advance the model, then check after the edge.
    task automatic cyc(input string tag, input bit v, input int d, input bit st);
        bit exp_redy;
        int s, mn, mx;
        in_valid = v;
        in_s     = N'(d);
        start    = st;
        exp_redy = 1'b0;
        if (!en) begin
            m_active = 1'b0;
            win_q.delete();
        end else if (!m_active) begin
            if (st || continuous) begin
                m_active = 1'b1;
                win_q.delete();
            end
        end else if (v) begin
            win_q.push_back(d);
            if (win_q.size() == WIN) begin
                s = 0; mn = 255; mx = 0;
                foreach (win_q[i]) begin
                    s += win_q[i];
                    if (win_q[i] < mn) mn = win_q[i];
                    if (win_q[i] > mx) mx = win_q[i];
                end
                h_sum = s;
                h_m1  = (s + WIN / 2) / WIN;
                h_m0  = s / WIN;
                h_min = mn;
                h_max = mx;
                exp_redy = 1'b1;
                win_q.delete();
                if (!continuous) m_active = 1'b0;
            end
        end
        @(posedge clk);
        cyc_n++;
        #1;
        if (r1_redy === 1'b1) pulses.push_back(cyc_n);
        check_outputs(tag, exp_redy);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        win_q.delete();
        h_sum = 0; h_m1 = 0; h_m0 = 0; h_min = 0; h_max = 0;
    endtask

    initial begin
        int seq[4];
        reset = 1'b0; en = 1'b0; start = 1'b0; continuous = 1'b0; in_valid = 1'b0; in_s = '0;
        model_reset();
        #12;
        check_outputs("reset", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;

        // Single-shot mean, rounded and truncated
        cyc("ss_start", 1'b0, 0, 1'b1);
        seq = '{10, 20, 30, 42};
        foreach (seq[i]) cyc("ss", 1'b1, seq[i], 1'b0);
        chk("ss.sum_const", 32'(r1_sum), 32'd102);
        chk("ss.mean_r1_const", 32'(r1_out), 32'd26);
        chk("ss.mean_r0_const", 32'(r0_out), 32'd25);
        cyc("ss_idle", 1'b1, 99, 1'b0);

        // Saturation bound
        cyc("sat_start", 1'b0, 0, 1'b1);
        for (int i = 0; i < WIN; i++) cyc("sat", 1'b1, 255, 1'b0);
        chk("sat.sum_const", 32'(r1_sum), 32'd1020);
        chk("sat.mean_const", 32'(r1_out), 32'd255);

        // Continuous, in_valid held high
        continuous = 1'b1;
        cyc("cont_arm", 1'b0, 0, 1'b0);
        pulses.delete();
        for (int i = 1; i <= 12; i++) cyc("cont", 1'b1, i, 1'b0);
        chk("cont.npulses", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            chk("cont.gap1", 32'(pulses[1] - pulses[0]), 32'd4);
            chk("cont.gap2", 32'(pulses[2] - pulses[1]), 32'd4);
        end
        chk("cont.last_sum", 32'(r1_sum), 32'd42);

        // Continuous with in_valid every other cycle
        pulses.delete();
        for (int i = 1; i <= 12; i++) begin
            cyc("gap_v", 1'b1, i, 1'b0);
            cyc("gap_n", 1'b0, 0, 1'b0);
        end
        chk("gap.npulses", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            chk("gap.gap1", 32'(pulses[1] - pulses[0]), 32'd8);
            chk("gap.gap2", 32'(pulses[2] - pulses[1]), 32'd8);
        end
        continuous = 1'b0;
        for (int i = 0; i < WIN; i++) cyc("cont_end", 1'b1, 3, 1'b0);

        // Abort after two samples, then a clean window
        cyc("ab_start", 1'b0, 0, 1'b1);
        cyc("ab", 1'b1, 200, 1'b0);
        cyc("ab", 1'b1, 100, 1'b0);
        en = 1'b0;
        cyc("ab_en0", 1'b1, 50, 1'b0);
        cyc("ab_en0b", 1'b0, 0, 1'b0);
        en = 1'b1;
        cyc("ab_restart", 1'b0, 0, 1'b1);
        seq = '{1, 2, 3, 4};
        foreach (seq[i]) cyc("ab_win", 1'b1, seq[i], 1'b0);

        // Asynchronous reset between edges, mid-window
        cyc("rst_start", 1'b0, 0, 1'b1);
        cyc("rst", 1'b1, 77, 1'b0);
        cyc("rst", 1'b1, 88, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc("rst_restart", 1'b0, 0, 1'b1);
        for (int i = 0; i < WIN; i++) cyc("rst_win", 1'b1, 7, 1'b0);
        chk("rst_win.mean_const", 32'(r1_out), 32'd7);

        // en falling with the final sample, start during ACC ignored
        cyc("sim_start", 1'b0, 0, 1'b1);
        cyc("sim", 1'b1, 9, 1'b0);
        cyc("sim", 1'b1, 9, 1'b0);
        cyc("sim", 1'b1, 9, 1'b0);
        en = 1'b0;
        cyc("sim_final_abort", 1'b1, 9, 1'b0);
        en = 1'b1;
        cyc("st_start", 1'b0, 0, 1'b1);
        cyc("st", 1'b1, 40, 1'b0);
        cyc("st_restart_ign", 1'b1, 60, 1'b1);
        cyc("st", 1'b1, 80, 1'b1);
        cyc("st_final", 1'b1, 100, 1'b0);
        chk("st.sum_const", 32'(r1_sum), 32'd280);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) continuous = ~continuous;
            en = ($urandom_range(0, 39) != 0);
            cyc("rnd", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                ($urandom_range(0, 7) == 0));
        end
        en = 1'b1;
        continuous = 1'b0;
        for (int i = 0; i < 8; i++) cyc("drain", 1'b1, int'($urandom_range(0, 255)), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/promedio_window.md
# promedio_window

Windowed sample averager for the ring-oscillator temperature-sensor datapath, successor to the fixed 100-count accumulator. Accumulates a parametrised power-of-two window of valid counter samples and reports the true mean (optionally rounded), the raw sum, and the window minimum and maximum. Supports single-shot and continuous back-to-back windows. Sits between the RO frequency counter and the readout/serializer logic.

## Interface
- `N`, 8: sample and mean width.
- `LOG2_WIN`, 7: window length is 2^LOG2_WIN samples; legal range is 1..16.
- `ROUND`, 1: 1 means round-half-up mean, 0 means truncated mean.

- `clk`  in  1  system clock; all flops are rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; low means synchronous abort and clear.
- `start`  in  1  single-cycle pulse that arms one window.
- `continuous`  in  1  when 1, windows restart automatically.
- `in_valid`  in  1  `in` carries a sample this cycle.
- `in`  in  N  sample, unsigned.
- `out`  out  N  mean of the last completed window.
- `out_min`  out  N  minimum of the last completed window.
- `out_max`  out  N  maximum of the last completed window.
- `sum_out`  out  N+LOG2_WIN  raw sum of the last completed window.
- `sum_redy`  out  1  one-cycle pulse: the result outputs were just updated.
- `busy`  out  1  high while a window is in progress.

## Operation
- **States:** IDLE and ACC.
- **IDLE:**
  - `busy` = 0.
  - Go to ACC when `en` & (`start` | `continuous`).
  - On entry to ACC: acc = 0, cnt = 0, min = all-ones, max = 0.
- **ACC, on each `in_valid`:**
  - acc += `in`; cnt++.
  - min = min(min, `in`); max = max(max, `in`).
  - Cycles without `in_valid` hold all state. There is no timeout.
- **Final sample** (`in_valid` with cnt == 2^LOG2_WIN−1):
  - The final values include this sample.
  - `sum_out` is loaded with acc+`in`; `out_min`/`out_max` get the final min/max.
  - `out` = (acc + `in` + (ROUND ? 2^(LOG2_WIN−1) : 0)) >> LOG2_WIN.
  - The rounding adder is N+LOG2_WIN+1 bits, so it never wraps. An all-ones input gives mean 2^N−1.
  - `sum_redy` is pulsed.
  - Next state: if `continuous` & `en`, stay in ACC with acc/cnt/min/max re-seeded. Otherwise go to IDLE.
- `start` in ACC is ignored. `continuous` falling mid-window finishes the current window, then goes to IDLE.
- **`en` low (any state):** go to IDLE next edge; clear acc/cnt; `busy` = 0; no `sum_redy`. Result outputs hold their last values.
- **`reset` low:**
  - Immediately: IDLE; acc, cnt, `out`, `out_min`, `out_max`, `sum_out` = 0; `sum_redy` = 0; `busy` = 0.
  - Mid-window: the partial window is discarded.
- Result outputs change only on the final-sample edge.

## Timing
- **`busy`:** rises the cycle after the `start` edge (the first sample may arrive in that cycle). It falls the cycle after the final-sample edge in single-shot mode and stays high in continuous mode.
- **Latency:** `sum_redy`, `out`, `out_min`, `out_max` and `sum_out` are valid the cycle after the final `in_valid`, i.e. one cycle of latency.
- **Continuous throughput:** with `in_valid` held high, no sample is dropped between windows, and `sum_redy` pulses every 2^LOG2_WIN cycles.
- **Simultaneous events:**
  - `start` with the final sample of a continuous window: `start` is ignored.
  - `en` falling with the final sample: the abort wins, and `sum_redy` stays 0.

## Structure
- Package `promedio_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_ACC`);
  - the accumulator-width function N+LOG2_WIN;
  - the rounding-constant function.
- Sub-module `promedio_minmax` (parameter N): running min/max registers with seed and update controls. It is instantiated once.
- Counter, accumulator, FSM and output registers stay in the top level.

## Test plan
All scenarios use N=8, LOG2_WIN=2 (window of 4).
1. **Single-shot mean.** `start`, then samples 10, 20, 30, 42, ROUND=1 → `sum_out`=102, `out`=26, `out_min`=10, `out_max`=42, one `sum_redy` pulse, then `busy`=0. Same stimulus with ROUND=0 → `out`=25.
2. **Saturation bound.** Four samples of 255 → `sum_out`=1020, `out`=255, no wrap.
3. **Continuous with gaps.** `continuous`=1, `in_valid` high for 12 cycles with samples 1..12 → three `sum_redy` pulses exactly 4 cycles apart, sums 10, 26, 42. Repeat with `in_valid` low every other cycle → pulses 8 cycles apart, same sums.
4. **Abort.** `en` driven low after 2 samples of a window → no `sum_redy`, outputs keep their prior values, `busy` falls the next cycle. A fresh `start` then yields a correct window.
5. **Reset mid-window.** `reset` asserted asynchronously between clock edges → all outputs read 0 before the next edge. After release, `start` plus 4 samples of 7 → `out`=7.
6. **Simultaneous events.** `en` falling on the final-sample edge → no pulse. `start` asserted during ACC → no effect on `cnt`.
